// File: rtl/uart_pgm_loader_if.sv
// RAM external program-port bundle: ownership flag, word address, word data, write strobe.
// Pure wiring, no latency; the loader drives every signal from registers.
// No backpressure; the RAM samples pg_wr through its own synchroniser and edge detector.
interface uart_pgm_loader_if;
   logic        pgm;
   logic [15:0] pgm_addr;
   logic [15:0] pgm_data;
   logic        pg_wr;

   modport master (output pgm, output pgm_addr, output pgm_data, output pg_wr);
   modport slave  (input  pgm, input  pgm_addr, input  pgm_data, input  pg_wr);
endinterface

// File: rtl/uart_pgm_loader.sv
// UART 8N1 boot loader: SYNC, LEN_HI, LEN_LO, then N 16-bit words written to RAM addresses 0..N-1.
// Latency: a word's write window opens the cycle after its low byte's stop bit; pg_wr high WR_HOLD, low WR_HOLD.
// No backpressure on rx; a byte finishing during a write window is parked and consumed afterwards.
// Optional trailing XOR checksum byte when UART_PGM_CSUM_EN is defined.
module uart_pgm_loader #(
   parameter int         CLKS_PER_BIT = 868,
   parameter int         WR_HOLD      = 4,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx,
   uart_pgm_loader_if.master  ram,
   output logic               cpu_rst,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int WW = $clog2(2 * WR_HOLD);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   typedef enum logic [3:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE,
`ifdef UART_PGM_CSUM_EN
      S_CSUM,
`endif
      S_DONE, S_ERR
   } state_t;

   // receiver state
   logic          rx_s1, rx_s2, rx_d;
   rx_state_t     rx_state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          byte_vld;
   logic          frame_err;

   // loader state
   state_t        state;
   logic [15:0]   len;
   logic [7:0]    hi_byte;
   logic [WW-1:0] wr_cnt;
   logic          pend_vld;
   logic          pend_ferr;
   logic [7:0]    pend_dat;
`ifdef UART_PGM_CSUM_EN
   logic [7:0]    csum;
`endif

   // receive events as seen by the loader: parked event first, otherwise the live one
   logic          in_write;
   logic          ev_byte;
   logic          ev_ferr;
   logic [7:0]    ev_dat;

   assign in_write = (state == S_WRITE);
   assign busy     = !(state == S_IDLE || state == S_DONE || state == S_ERR);

   // select the byte/framing event the loader acts on this cycle (none while writing)
   always_comb begin
      ev_byte = 1'b0;
      ev_ferr = 1'b0;
      ev_dat  = shift;
      if (!in_write) begin
         if (pend_vld) begin
            ev_byte = !pend_ferr;
            ev_ferr = pend_ferr;
            ev_dat  = pend_dat;
         end else begin
            ev_byte = byte_vld;
            ev_ferr = frame_err;
         end
      end
   end

   // rx synchroniser and 8N1 byte receiver with mid-bit sampling
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_d      <= 1'b1;
         rx_state  <= RX_IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         byte_vld  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_s1     <= rx;
         rx_s2     <= rx_s1;
         rx_d      <= rx_s2;
         byte_vld  <= 1'b0;
         frame_err <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               clk_cnt <= '0;
               if (rx_d && !rx_s2) rx_state <= RX_START;
            end
            RX_START: begin
               if (clk_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
                  clk_cnt  <= '0;
                  bit_idx  <= '0;
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                  clk_cnt <= '0;
                  shift   <= {rx_s2, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) rx_state <= RX_STOP;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: begin
               if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                  clk_cnt   <= '0;
                  byte_vld  <= rx_s2;
                  frame_err <= !rx_s2;
                  rx_state  <= RX_IDLE;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // load protocol FSM driving the program port, CPU reset and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         ram.pgm      <= 1'b0;
         ram.pgm_addr <= '0;
         ram.pgm_data <= '0;
         ram.pg_wr    <= 1'b0;
         cpu_rst      <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         len          <= '0;
         hi_byte      <= '0;
         wr_cnt       <= '0;
         pend_vld     <= 1'b0;
         pend_ferr    <= 1'b0;
         pend_dat     <= '0;
`ifdef UART_PGM_CSUM_EN
         csum         <= '0;
`endif
      end else begin
         // park an event that lands during a write window, or behind an unconsumed one
         if ((byte_vld || frame_err) && (in_write || pend_vld)) begin
            pend_vld  <= 1'b1;
            pend_ferr <= frame_err;
            pend_dat  <= shift;
         end else if (!in_write && pend_vld) begin
            pend_vld <= 1'b0;
         end

         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (ev_byte && ev_dat == SYNC_BYTE) begin
                  state   <= S_LEN_HI;
                  done    <= 1'b0;
                  err     <= 1'b0;
                  ram.pgm <= 1'b1;
                  cpu_rst <= 1'b1;
`ifdef UART_PGM_CSUM_EN
                  csum    <= '0;
`endif
               end
            end
            S_WRITE: begin
               wr_cnt <= wr_cnt + 1'b1;
               if (wr_cnt == WW'(WR_HOLD - 1)) ram.pg_wr <= 1'b0;
               if (wr_cnt == WW'(2 * WR_HOLD - 1)) begin
                  if (ram.pgm_addr + 16'd1 == len) begin
`ifdef UART_PGM_CSUM_EN
                     state   <= S_CSUM;
`else
                     state   <= S_DONE;
                     ram.pgm <= 1'b0;
                     cpu_rst <= 1'b0;
                     done    <= 1'b1;
`endif
                  end else begin
                     ram.pgm_addr <= ram.pgm_addr + 16'd1;
                     state        <= S_DATA_HI;
                  end
               end
            end
            default: begin
               if (ev_ferr) begin
                  state     <= S_ERR;
                  ram.pgm   <= 1'b0;
                  ram.pg_wr <= 1'b0;
                  cpu_rst   <= 1'b0;
                  err       <= 1'b1;
               end else if (ev_byte) begin
                  case (state)
                     S_LEN_HI: begin
                        len[15:8] <= ev_dat;
                        state     <= S_LEN_LO;
                     end
                     S_LEN_LO: begin
                        len[7:0] <= ev_dat;
                        if ({len[15:8], ev_dat} == 16'd0) begin
                           state   <= S_DONE;
                           ram.pgm <= 1'b0;
                           cpu_rst <= 1'b0;
                           done    <= 1'b1;
                        end else begin
                           ram.pgm_addr <= '0;
                           state        <= S_DATA_HI;
                        end
                     end
                     S_DATA_HI: begin
                        hi_byte <= ev_dat;
`ifdef UART_PGM_CSUM_EN
                        csum    <= csum ^ ev_dat;
`endif
                        state   <= S_DATA_LO;
                     end
                     S_DATA_LO: begin
                        ram.pgm_data <= {hi_byte, ev_dat};
`ifdef UART_PGM_CSUM_EN
                        csum         <= csum ^ ev_dat;
`endif
                        ram.pg_wr    <= 1'b1;
                        wr_cnt       <= '0;
                        state        <= S_WRITE;
                     end
`ifdef UART_PGM_CSUM_EN
                     S_CSUM: begin
                        ram.pgm <= 1'b0;
                        cpu_rst <= 1'b0;
                        if (ev_dat == csum) begin
                           state <= S_DONE;
                           done  <= 1'b1;
                        end else begin
                           state <= S_ERR;
                           err   <= 1'b1;
                        end
                     end
`endif
                     default: state <= state;
                  endcase
               end
            end
         endcase
      end
   end

endmodule
